// File: rtl/ogr_result_streamer_pkg.sv
// rtl/ogr_result_streamer_pkg.sv - shared sizes and FSM states for the OGR result streamer
package ogr_result_streamer_pkg;
    localparam int OGR_NUMPOSITIONS = 5;
    localparam int OGR_POSW         = 8;
    localparam int OGR_NUMRESULTS   = 5;
    localparam int OGR_RULERW       = (OGR_NUMPOSITIONS + 1) * OGR_POSW;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TAIL,
        ST_FINISHED
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ogr_result_buffer.sv
// rtl/ogr_result_buffer.sv - NUMRESULTS-deep ruler register file with flush/append/indexed read
import ogr_result_streamer_pkg::*;

module ogr_result_buffer #(
    parameter int RULERW     = OGR_RULERW,
    parameter int NUMRESULTS = OGR_NUMRESULTS,
    parameter int IDXW       = idx_width(NUMRESULTS)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_append,
    input  logic [RULERW-1:0] i_wr_data,
    input  logic [IDXW-1:0]   i_rd_idx,
    output logic [RULERW-1:0] o_rd_data,
    output logic [5:0]        o_count
);
    logic [RULERW-1:0] r_mem [NUMRESULTS];
    logic [5:0]        r_count;
    logic [5:0]        w_wr_slot;

    // flush together with append restarts the buffer with the new ruler in slot 0
    assign w_wr_slot = i_flush ? 6'd0 : r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= 6'd0;
            for (int i = 0; i < NUMRESULTS; i++) r_mem[i] <= '0;
        end else if (i_append) begin
            r_mem[w_wr_slot[IDXW-1:0]] <= i_wr_data;
            r_count                    <= w_wr_slot + 6'd1;
        end else if (i_flush) begin
            r_count <= 6'd0;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];
    assign o_count   = r_count;
endmodule

// File: rtl/ogr_result_streamer.sv
// rtl/ogr_result_streamer.sv - keeps shortest Golomb rulers and streams them bytewise; OGR_RESULT_CHECKSUM_EN adds XOR tail byte
import ogr_result_streamer_pkg::*;

module ogr_result_streamer #(
    parameter int NUMPOSITIONS = OGR_NUMPOSITIONS,
    parameter int POSW         = OGR_POSW,
    parameter int NUMRESULTS   = OGR_NUMRESULTS
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_cand_valid,
    input  logic [(NUMPOSITIONS+1)*POSW-1:0] i_cand_marks,
    input  logic                           i_search_done,
    output logic [POSW-1:0]                o_best_len,
    output logic [5:0]                     o_num_results,
    output logic                           o_overflow,
    output logic [7:0]                     o_tx_data,
    output logic                           o_tx_valid,
    input  logic                           i_tx_ready,
    output logic                           o_stream_done
);
    localparam int RULERW = (NUMPOSITIONS + 1) * POSW;
    localparam int IDXW   = idx_width(NUMRESULTS);
    localparam int POSIW  = idx_width(NUMPOSITIONS + 1);
    localparam logic [5:0]       NR6     = 6'(NUMRESULTS);
    localparam logic [POSIW-1:0] LASTPOS = POSIW'(NUMPOSITIONS);

    state_t            r_state, w_next;
    logic [POSW-1:0]   r_best_len, w_cand_len, w_mark;
    logic              r_overflow;
    logic [5:0]        w_count, r_slot;
    logic [POSIW-1:0]  r_pos;
    logic              w_take, w_flush, w_append, w_drop_full;
    logic              w_last_mark, w_last_slot, w_hs;
    logic [RULERW-1:0] w_rd_ruler;
    logic [7:0]        w_tx_data;
    logic              w_tx_valid;

    assign w_cand_len  = i_cand_marks[POSW-1:0];
    assign w_take      = (r_state == ST_COLLECT) && i_cand_valid;
    assign w_flush     = w_take && (w_cand_len < r_best_len);
    assign w_append    = w_flush || (w_take && (w_cand_len == r_best_len) && (w_count < NR6));
    assign w_drop_full = w_take && (w_cand_len == r_best_len) && (w_count == NR6);

    ogr_result_buffer #(.RULERW(RULERW), .NUMRESULTS(NUMRESULTS), .IDXW(IDXW)) u_buffer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_flush   (w_flush),
        .i_append  (w_append),
        .i_wr_data (i_cand_marks),
        .i_rd_idx  (r_slot[IDXW-1:0]),
        .o_rd_data (w_rd_ruler),
        .o_count   (w_count)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_best_len <= '1;
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_best_len <= w_cand_len;
            r_overflow <= 1'b0;
        end else if (w_drop_full) begin
            r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_mark = '0;
        for (int k = 0; k <= NUMPOSITIONS; k++)
            if (r_pos == POSIW'(k)) w_mark = w_rd_ruler[(NUMPOSITIONS-k)*POSW +: POSW];
    end

    assign w_last_mark = (r_pos == LASTPOS);
    assign w_last_slot = (r_slot == w_count - 6'd1);
    assign w_hs        = w_tx_valid && i_tx_ready;

`ifdef OGR_RESULT_CHECKSUM_EN
    logic [7:0] r_csum;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)                    r_csum <= 8'd0;
        else if (r_state == ST_COLLECT) r_csum <= 8'd0;
        else if (w_hs)                  r_csum <= r_csum ^ w_tx_data;
    end
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_COLLECT;
        else         r_state <= w_next;
    end

    // tx byte is decoded only from registered state, so it stays put during a stall
    always_comb begin
        w_next     = r_state;
        w_tx_valid = 1'b0;
        w_tx_data  = 8'd0;
        case (r_state)
            ST_COLLECT: if (i_search_done) w_next = ST_HEADER;
            ST_HEADER: begin
                w_tx_valid = 1'b1;
                w_tx_data  = {r_overflow, 1'b0, w_count};
                if (i_tx_ready) w_next = (w_count == 6'd0) ? ST_TAIL : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'(w_mark);
                if (i_tx_ready && w_last_mark && w_last_slot) w_next = ST_TAIL;
            end
            ST_TAIL: begin
`ifdef OGR_RESULT_CHECKSUM_EN
                w_tx_valid = 1'b1;
                w_tx_data  = r_csum;
                if (i_tx_ready) w_next = ST_FINISHED;
`else
                w_next = ST_FINISHED;
`endif
            end
            ST_FINISHED: w_next = ST_FINISHED;
            default:     w_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_slot <= 6'd0;
            r_pos  <= '0;
        end else if (r_state == ST_HEADER) begin
            r_slot <= 6'd0;
            r_pos  <= '0;
        end else if (r_state == ST_PAYLOAD && w_hs) begin
            if (w_last_mark) begin
                r_pos  <= '0;
                r_slot <= r_slot + 6'd1;
            end else begin
                r_pos <= r_pos + 1'b1;
            end
        end
    end

    assign o_best_len    = r_best_len;
    assign o_num_results = w_count;
    assign o_overflow    = r_overflow;
    assign o_tx_data     = w_tx_data;
    assign o_tx_valid    = w_tx_valid;
    assign o_stream_done = (r_state == ST_FINISHED);
endmodule
